avlmm_host: RTL
===============

// Module: avlmm_host
// PURPOSE
// - Avalon-MM host (initiator) that turns single commands into one Avalon-MM read or write each.
// - Drives register-file agents such as the xg_eth/sync/pack control register banks.
// - Sits between a local controller (sequencer/CPU bridge) and the Avalon-MM agent port.
// - Honours waitrequest, supports fixed read latency, aborts stalled transfers on timeout.
// PARAMETERS
// - WORD_WIDTH      32  data bit width, matches agent word width
// - ADDR_WIDTH      5   word address bit width
// - READ_LATENCY    0   cycles from accepted read (waitrequest low) to valid readdata; 0..7
// - TIMEOUT_CYCLES  256 max cycles read/write held with waitrequest high before abort; 0 = never
// PORTS
// - clk            in   1           clock, posedge active
// - rst_n          in   1           reset; asynchronous, active-low
// - cmd_valid      in   1           command present
// - cmd_ready      out  1           block accepts a command (state IDLE)
// - cmd_write      in   1           1 = write, 0 = read
// - cmd_address    in   ADDR_WIDTH  word address
// - cmd_writedata  in   WORD_WIDTH  write data (ignored for reads)
// - rsp_valid      out  1           response present
// - rsp_ready      in   1           response consumed
// - rsp_readdata   out  WORD_WIDTH  read data; 0 for writes and on error
// - rsp_error      out  1           1 = transfer aborted by timeout
// - read           out  1           Avalon-MM read
// - write          out  1           Avalon-MM write
// - address        out  ADDR_WIDTH  Avalon-MM address
// - writedata      out  WORD_WIDTH  Avalon-MM write data
// - readdata       in   WORD_WIDTH  Avalon-MM read data
// - waitrequest    in   1           Avalon-MM wait request
// BEHAVIOUR
// - Reset (async, rst_n low):
//   - State IDLE; read/write/address/writedata/rsp_* all 0; cmd_ready = 1.
//   - Reset mid-transfer drops read/write immediately; no response is issued for the aborted command.
// - FSM IDLE -> REQ -> [RLAT] -> RSP -> IDLE.
//   - IDLE: cmd_ready=1. On cmd_valid, register cmd_* into address/writedata and set read or write
//     next cycle (command accepted in cycle N => read/write high in N+1); go REQ.
//   - REQ: read/write, address, writedata held stable while waitrequest=1.
//     - First cycle with waitrequest=0 completes the bus transfer; read/write low the following cycle.
//     - Write done -> RSP, rsp_readdata=0, rsp_error=0.
//     - Read with READ_LATENCY=0: capture readdata in the same cycle -> RSP.
//     - Read with READ_LATENCY>0 -> RLAT.
//   - RLAT: count READ_LATENCY cycles after the accept cycle; capture readdata on the last cycle -> RSP.
//   - RSP: rsp_valid=1; rsp_* stable until rsp_ready=1, then IDLE.
//     - rsp_valid falls and cmd_ready rises in the next cycle.
// - Throughput and ordering:
//   - Single outstanding command; no back-to-back overlap.
//   - Minimum write turnaround is 3 cycles (accept, bus, rsp).
// - Timeout: cycle counter ($clog2(TIMEOUT_CYCLES+1) bits) clears on REQ entry.
//   - Increments each REQ cycle with waitrequest=1.
//   - Reaching TIMEOUT_CYCLES: drop read/write next cycle, go RSP with rsp_error=1, rsp_readdata=0.
//   - waitrequest falling in the same cycle the limit is reached: normal completion wins, rsp_error=0.
// - cmd_* is sampled only when cmd_valid & cmd_ready; changes at other times are ignored.
// - cmd_valid held during RSP is not accepted until IDLE.
// STRUCTURE
// - Package avlmm_pkg:
//   - state enum typedef avlmm_host_state_t {IDLE, REQ, RLAT, RSP}.
//   - localparam for maximum READ_LATENCY (7).
// - Sub-module avlmm_tmo_cnt: loadable up-counter with terminal flag.
//   - Used for both the timeout count and the RLAT count (two instances).
// - Everything else lives in avlmm_host: FSM, output registers, response registers.
// TESTING
// - Write/read loop against a 15-word zero-wait agent, READ_LATENCY=0:
//   - write addr 3 = 0xDEADBEEF, then read addr 3.
//   - Expect write high exactly 1 cycle; rsp_readdata = 0xDEADBEEF, rsp_error = 0.
// - Wait states: agent holds waitrequest=1 for 3 cycles on a read of addr 7.
//   - read, address and writedata stay stable for 4 cycles.
//   - rsp_valid rises 1 cycle after waitrequest falls.
// - Timeout: TIMEOUT_CYCLES=16, waitrequest stuck at 1.
//   - read drops after 16 stall cycles; rsp_error = 1, rsp_readdata = 0.
//   - Next command is accepted normally afterwards.
// - Read latency: READ_LATENCY=2, agent returns 0x12345678 two cycles after accept.
//   - rsp_readdata = 0x12345678; stale readdata on other cycles is not captured.
// - Backpressure: rsp_ready held low for 5 cycles.
//   - rsp_* stable, cmd_ready stays 0, a second cmd_valid is not accepted until the cycle after rsp_ready.
// - Reset mid-transfer: assert rst_n low while in REQ with waitrequest=1.
//   - read/write go 0 asynchronously, no rsp_valid; cmd_ready = 1 after release.

Source files
------------

// File: rtl/avlmm_pkg.sv
// Shared state encoding and limits for the Avalon-MM host and its counters.
package avlmm_pkg;

    typedef enum logic [1:0] {IDLE, REQ, RLAT, RSP} avlmm_host_state_t;

    localparam int MAX_READ_LATENCY = 7;

endpackage

// File: rtl/avlmm_tmo_cnt.sv
// Clearable up-counter whose terminal flag marks the cycle it holds the programmed last value.
module avlmm_tmo_cnt
    import avlmm_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    input  logic [WIDTH-1:0] last,
    output logic             term
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Not gated by inc so the caller can qualify it without a combinational loop.
    assign term = (cnt_q == last);

endmodule

// File: rtl/avlmm_host.sv
// Avalon-MM host: one command becomes one bus read or write with wait-state handling,
// fixed read latency and a stall timeout that returns an error response.
module avlmm_host
    import avlmm_pkg::*;
#(
    parameter int WORD_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 5,
    parameter int READ_LATENCY   = 0,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_address,
    input  logic [WORD_WIDTH-1:0] cmd_writedata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WORD_WIDTH-1:0] rsp_readdata,
    output logic                  rsp_error,
    output logic                  read,
    output logic                  write,
    output logic [ADDR_WIDTH-1:0] address,
    output logic [WORD_WIDTH-1:0] writedata,
    input  logic [WORD_WIDTH-1:0] readdata,
    input  logic                  waitrequest
);

    localparam int TMO_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int LAT_W = $clog2(MAX_READ_LATENCY + 1);
    localparam bit TMO_EN = (TIMEOUT_CYCLES > 0);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'((READ_LATENCY > 0) ? READ_LATENCY - 1 : 0);

    avlmm_host_state_t     state_q, state_d;
    logic                  read_q, read_d;
    logic                  write_q, write_d;
    logic [ADDR_WIDTH-1:0] address_q, address_d;
    logic [WORD_WIDTH-1:0] writedata_q, writedata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [WORD_WIDTH-1:0] rsp_readdata_q, rsp_readdata_d;
    logic                  rsp_error_q, rsp_error_d;
    logic                  tmo_clr, tmo_inc, tmo_term;
    logic                  lat_clr, lat_inc, lat_term;

    avlmm_tmo_cnt #(.WIDTH(TMO_W)) u_tmo_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (tmo_clr),
        .inc   (tmo_inc),
        .last  (TMO_LAST),
        .term  (tmo_term)
    );

    avlmm_tmo_cnt #(.WIDTH(LAT_W)) u_lat_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (lat_clr),
        .inc   (lat_inc),
        .last  (LAT_LAST),
        .term  (lat_term)
    );

    always_comb begin
        state_d        = state_q;
        read_d         = read_q;
        write_d        = write_q;
        address_d      = address_q;
        writedata_d    = writedata_q;
        rsp_valid_d    = rsp_valid_q;
        rsp_readdata_d = rsp_readdata_q;
        rsp_error_d    = rsp_error_q;
        tmo_clr        = 1'b0;
        tmo_inc        = 1'b0;
        lat_clr        = 1'b0;
        lat_inc        = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    address_d   = cmd_address;
                    writedata_d = cmd_writedata;
                    read_d      = ~cmd_write;
                    write_d     = cmd_write;
                    tmo_clr     = 1'b1;
                    state_d     = REQ;
                end
            end
            REQ: begin
                if (!waitrequest) begin
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    if (write_q || READ_LATENCY == 0) begin
                        rsp_valid_d    = 1'b1;
                        rsp_readdata_d = write_q ? '0 : readdata;
                        rsp_error_d    = 1'b0;
                        state_d        = RSP;
                    end else begin
                        lat_clr = 1'b1;
                        state_d = RLAT;
                    end
                end else begin
                    // Abort on the TIMEOUT_CYCLES-th consecutive stall; a completing
                    // cycle never counts, so normal completion always wins.
                    tmo_inc = 1'b1;
                    if (TMO_EN && tmo_term) begin
                        read_d         = 1'b0;
                        write_d        = 1'b0;
                        rsp_valid_d    = 1'b1;
                        rsp_readdata_d = '0;
                        rsp_error_d    = 1'b1;
                        state_d        = RSP;
                    end
                end
            end
            RLAT: begin
                lat_inc = 1'b1;
                if (lat_term) begin
                    rsp_valid_d    = 1'b1;
                    rsp_readdata_d = readdata;
                    rsp_error_d    = 1'b0;
                    state_d        = RSP;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            read_q         <= 1'b0;
            write_q        <= 1'b0;
            address_q      <= '0;
            writedata_q    <= '0;
            rsp_valid_q    <= 1'b0;
            rsp_readdata_q <= '0;
            rsp_error_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            read_q         <= read_d;
            write_q        <= write_d;
            address_q      <= address_d;
            writedata_q    <= writedata_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_readdata_q <= rsp_readdata_d;
            rsp_error_q    <= rsp_error_d;
        end
    end

    assign cmd_ready    = (state_q == IDLE);
    assign read         = read_q;
    assign write        = write_q;
    assign address      = address_q;
    assign writedata    = writedata_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_readdata = rsp_readdata_q;
    assign rsp_error    = rsp_error_q;

endmodule
